// File: rtl/div_seq_if.sv
// Request/result bundle for the sequential divider: operands and start come from
// the master, and busy/done/results/flags come back from the divider (slave).
interface div_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             n_flag;
  logic             z_flag;
  logic             dz_flag;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, n_flag, z_flag, dz_flag
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, n_flag, z_flag, dz_flag
  );
endinterface

// File: rtl/div_seq.sv
// Restoring shift-subtract divider, one quotient bit per cycle (IDLE/RUN/FIX/DONE).
// Define DIV_SEQ_SIGNED_EN to honour signed_op; otherwise every division is unsigned.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  div_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   part_sh;
  logic [WIDTH-1:0] part_sub;
  logic             q_ge;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_fix, r_fix;

`ifdef DIV_SEQ_SIGNED_EN
  logic a_neg, b_neg;
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  always_comb begin
    a_neg = bus.signed_op & bus.dividend[WIDTH-1];
    b_neg = bus.signed_op & bus.divisor[WIDTH-1];
    a_mag = a_neg ? -bus.dividend : bus.dividend;
    b_mag = b_neg ? -bus.divisor  : bus.divisor;
    // Truncating division: quotient sign from sign mismatch, remainder follows dividend
    q_fix = qneg_q ? -shreg_q : shreg_q;
    r_fix = rneg_q ? -part_q  : part_q;
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = bus.signed_op;
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
  assign q_fix = shreg_q;
  assign r_fix = part_q;
`endif

  // One restoring step: shift the next dividend bit into the partial remainder
  assign part_sh  = {part_q, shreg_q[WIDTH-1]};
  assign q_ge     = (part_sh >= {1'b0, dvs_q});
  assign part_sub = part_sh[WIDTH-1:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    shreg_d = shreg_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    n_d     = n_q;
    z_d     = z_q;
    dz_d    = dz_q;
    busy_d  = (state_q == S_RUN) || (state_q == S_FIX);
    done_d  = (state_q == S_DONE);
`ifdef DIV_SEQ_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            quot_d  = '1;
            rem_d   = bus.dividend;
            n_d     = 1'b1;
            z_d     = 1'b0;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            part_d  = '0;
            shreg_d = a_mag;
            dvs_d   = b_mag;
            cnt_d   = '0;
            state_d = S_RUN;
`ifdef DIV_SEQ_SIGNED_EN
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
`endif
          end
        end
      end
      S_RUN: begin
        if (q_ge) begin
          part_d  = part_sub;
          shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
        end else begin
          part_d  = part_sh[WIDTH-1:0];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quot_d  = q_fix;
        rem_d   = r_fix;
        n_d     = q_fix[WIDTH-1];
        z_d     = (q_fix == '0);
        dz_d    = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
      shreg_q <= '0;
      dvs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      dz_q    <= 1'b0;
`ifdef DIV_SEQ_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      shreg_q <= shreg_d;
      dvs_q   <= dvs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      n_q     <= n_d;
      z_q     <= z_d;
      dz_q    <= dz_d;
`ifdef DIV_SEQ_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.n_flag    = n_q;
  assign bus.z_flag    = z_q;
  assign bus.dz_flag   = dz_q;
endmodule

// File: tb/tb_div_seq.sv
// Randomized scoreboard bench for div_seq: the driver queues expected results from an
// arithmetic reference model, and a monitor pops and compares on every done pulse.
module tb_div_seq;
  localparam int W = 32;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         n;
    logic         z;
    logic         dz;
    int           k;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  div_seq_if #(.WIDTH(W)) bus ();

  div_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    logic   sgn;
    longint sa, sb_v;
`ifdef DIV_SEQ_SIGNED_EN
    sgn = sop;
`else
    sgn = sop && 1'b0;
`endif
    e.dz = 1'b0;
    e.k  = 0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else if (!sgn) begin
      e.q = a / b;
      e.r = a % b;
    end else if (a == MINV && b == '1) begin
      e.q = MINV;
      e.r = '0;
    end else begin
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      e.q  = W'(sa / sb_v);
      e.r  = W'(sa % sb_v);
    end
    e.n = e.q[W-1];
    e.z = (e.q == '0);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 64'(bus.done), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("quotient",  64'(bus.quotient),  64'(e.q));
          chk("remainder", 64'(bus.remainder), 64'(e.r));
          chk("n_flag",    64'(bus.n_flag),    64'(e.n));
          chk("z_flag",    64'(bus.z_flag),    64'(e.z));
          chk("dz_flag",   64'(bus.dz_flag),   64'(e.dz));
          chk("done_cycle", 64'(cyc), 64'(e.k));
          chk("busy_at_done", 64'(bus.busy), 64'd0);
          $display("txn q=0x%08h r=0x%08h n=%0b z=%0b dz=%0b at cycle %0d",
                   bus.quotient, bus.remainder, bus.n_flag, bus.z_flag, bus.dz_flag, cyc);
        end
      end
    end
  end

  // Issue one division (called just after a negedge) and return once its done is seen
  task automatic run_one(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   k;
    bit   seen;
    reset         = 1'b0;
    bus.start     = 1'b1;
    bus.signed_op = sop;
    bus.dividend  = a;
    bus.divisor   = b;
    k   = cyc + 1;
    e   = model(sop, a, b);
    e.k = (b == '0) ? k + 1 : k + W + 2;
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < W + 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1 && $urandom_range(0, 3) == 0) begin
        bus.start     = 1'b1;
        bus.signed_op = 1'($urandom);
        bus.dividend  = $urandom;
        bus.divisor   = $urandom_range(0, 3);
      end else begin
        bus.start = 1'b0;
      end
      if (b != '0 && cyc == k + 1) chk("busy_in_run", 64'(bus.busy), 64'd1);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    bus.start = 1'b0;
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [W-1:0] a, b;
    int k;
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    int           k;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_quot", 64'(bus.quotient), 64'd0);
    chk("rst_rem",  64'(bus.remainder), 64'd0);
    chk("rst_n",    64'(bus.n_flag), 64'd0);
    chk("rst_z",    64'(bus.z_flag), 64'd0);
    chk("rst_dz",   64'(bus.dz_flag), 64'd0);

    // First start coincides with reset release
    run_one(1'b0, 32'd100, 32'd7);
    run_one(1'b1, 32'hFFFF_FFF9, 32'd2);
    run_one(1'b0, 32'd5, 32'd0);
    run_one(1'b0, 32'd3, 32'd7);
    run_one(1'b1, MINV, 32'hFFFF_FFFF);
    run_one(1'b1, 32'd7, 32'hFFFF_FFFE);
    run_one(1'b0, 32'hFFFF_FFFF, 32'd1);

    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: b = W'($urandom_range(1, 15));
        3: a = MINV;
        default: ;
      endcase
      run_one(1'($urandom), a, b);
    end

    // Abort a division with reset during its 10th RUN cycle
    bus.start     = 1'b1;
    bus.signed_op = 1'b0;
    bus.dividend  = 32'd12345;
    bus.divisor   = 32'd67;
    k = cyc + 1;
    while (cyc < k + 9) begin
      @(negedge clk);
      bus.start = 1'($urandom);
    end
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_quot", 64'(bus.quotient), 64'd0);
    chk("abort_rem",  64'(bus.remainder), 64'd0);
    chk("abort_n",    64'(bus.n_flag), 64'd0);
    chk("abort_z",    64'(bus.z_flag), 64'd0);
    chk("abort_dz",   64'(bus.dz_flag), 64'd0);
    repeat (W + 5) @(negedge clk);
    run_one(1'b0, 32'd9, 32'd3);

    repeat (5) @(negedge clk);
    chk("pending_results", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 32, giving the operand and result width in bits; legal values are 8 to 64.
REQ-002 The block SHALL have an input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have an input reset, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have an input start, 1 bit: request a division, sampled only in IDLE.
REQ-005 The block SHALL have an input signed_op, 1 bit: 1 selects two's-complement division, 0 selects unsigned.
REQ-006 The block SHALL have an input dividend, WIDTH bits: the numerator, sampled with start.
REQ-007 The block SHALL have an input divisor, WIDTH bits: the denominator, sampled with start.
REQ-008 The block SHALL have an output busy, 1 bit: high while a division is in progress (RUN or FIX).
REQ-009 The block SHALL have an output done, 1 bit: a one-cycle pulse marking the results valid.
REQ-010 The block SHALL have an output quotient, WIDTH bits: registered quotient (LO).
REQ-011 The block SHALL have an output remainder, WIDTH bits: registered remainder (HI).
REQ-012 The block SHALL have outputs n_flag, z_flag and dz_flag, 1 bit each: negative quotient, zero quotient, and divide-by-zero.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN, FIX and DONE.
REQ-014 In IDLE, start=1 SHALL latch the operands and signed_op, then go to RUN with the iteration counter at 0; in signed mode, operands SHALL be converted to magnitudes and their signs stored.
REQ-015 RUN SHALL perform one restoring shift-subtract iteration per cycle, producing one quotient bit per cycle, MSB first, for exactly WIDTH cycles, then go to FIX.
REQ-016 FIX SHALL apply sign correction and load the quotient, remainder and flag registers, then go to DONE.
REQ-017 In signed mode, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend (truncating division).
REQ-018 DONE SHALL hold done=1 for exactly one cycle, then go to IDLE.
REQ-019 Latency SHALL be fixed: if start is sampled at edge k, done is high for the cycle between edges k+WIDTH+2 and k+WIDTH+3.
REQ-020 If divisor is 0, the block SHALL go from IDLE directly to DONE, bypassing RUN and FIX, with quotient all ones, remainder = dividend, dz_flag=1 and n_flag/z_flag from that quotient.
REQ-021 Signed overflow (the most negative value divided by -1) SHALL give quotient = the most negative value, remainder = 0 and dz_flag=0.
REQ-022 start SHALL be ignored in RUN, FIX and DONE, with no queuing and no effect on the operation in progress.
REQ-023 The quotient, remainder and flag outputs SHALL hold their values from FIX/DONE until the next FIX or divide-by-zero DONE, or until reset.
REQ-024 n_flag SHALL equal quotient[WIDTH-1] and z_flag SHALL equal (quotient == 0), both taken from the registered quotient and independent of the remainder.
REQ-025 dz_flag SHALL be 0 for every completion with a nonzero divisor.

Reset
REQ-026 With reset=1 at a rising edge, the FSM SHALL go to IDLE and busy, done, quotient, remainder, n_flag, z_flag, dz_flag and the counter SHALL all be 0.
REQ-027 Reset SHALL take priority over start and SHALL abort any division in progress, with no done pulse produced for that operation.
REQ-028 A start sampled at the first edge with reset=0 SHALL be accepted normally.

Configuration
REQ-029 Macro DIV_SEQ_SIGNED_EN defined: signed_op SHALL be honoured as given in REQ-014 and REQ-017.
REQ-030 Macro DIV_SEQ_SIGNED_EN undefined: signed_op SHALL be ignored, all divisions SHALL be unsigned, and no sign-correction logic SHALL be built; latency SHALL be unchanged.

Verification
REQ-031 With WIDTH=32, unsigned 100/7, start at edge 0 -> quotient=14, remainder=2, n=0, z=0, dz=0, done high only between edges 34 and 35; busy high from edge 1 to edge 34.
REQ-032 With signed -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, n_flag=1, z_flag=0.
REQ-033 With 5/0 -> done high two cycles after start, quotient=0xFFFFFFFF, remainder=5, dz_flag=1, n_flag=1; and unsigned 3/7 -> quotient=0, remainder=3, z_flag=1.
REQ-034 With signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, n_flag=1, dz_flag=0.
REQ-035 With reset pulsed at the 10th RUN cycle, plus start pulses during RUN -> no done pulse, all outputs 0 after reset, and a following 9/3 -> quotient=3, remainder=0 with nominal latency.
REQ-036 With DIV_SEQ_SIGNED_EN undefined and signed_op=1, 0xFFFFFFF9 / 2 -> quotient=0x7FFFFFFC, remainder=1, n_flag=0.
